// File: rtl/latency_meas_pkg.sv
// Shared definitions for the latency-measurement video generator:
// FSM state encoding, 1080p60 timing defaults, colours and status LED layout.
package latency_meas_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_FLASH = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // CEA-861 1920x1080p60 timing at 148.5 MHz
   localparam int DEF_H_ACTIVE = 1920;
   localparam int DEF_H_FP     = 88;
   localparam int DEF_H_SYNC   = 44;
   localparam int DEF_H_BP     = 148;
   localparam int DEF_V_ACTIVE = 1080;
   localparam int DEF_V_FP     = 4;
   localparam int DEF_V_SYNC   = 5;
   localparam int DEF_V_BP     = 36;

   localparam logic [23:0] WHITE = 24'hFF_FF_FF;
   localparam logic [23:0] RED   = 24'hFF_00_00;
   localparam logic [23:0] GRN   = 24'h00_FF_00;
   localparam logic [23:0] BLU   = 24'h00_00_FF;

   localparam int LED_ARMED   = 0;
   localparam int LED_FLASH   = 1;
   localparam int LED_HIT     = 2;
   localparam int LED_TIMEOUT = 3;

   // Idle colour from the switch bank: each switch adds one primary.
   function automatic logic [23:0] idle_colour(input logic [2:0] sw);
      logic [23:0] c;
      c = '0;
      if (sw[0]) c = c | BLU;
      if (sw[1]) c = c | GRN;
      if (sw[2]) c = c | RED;
      return c;
   endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Programmable raster timing generator. Counters are exposed raw; sync and
// data-enable are registered so they line up with a registered pixel path.
module video_timing_gen
   import latency_meas_pkg::*;
#(
   parameter int H_ACTIVE  = DEF_H_ACTIVE,
   parameter int H_FP      = DEF_H_FP,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BP      = DEF_H_BP,
   parameter int V_ACTIVE  = DEF_V_ACTIVE,
   parameter int V_FP      = DEF_V_FP,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BP      = DEF_V_BP,
   parameter bit SYNC_POL  = 1'b1,
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int H_W      = $clog2(H_TOTAL),
   localparam int V_W      = $clog2(V_TOTAL)
) (
   input  logic           clk_i,
   input  logic           rst_n_i,
   output logic [H_W-1:0] h_cnt_o,
   output logic [V_W-1:0] v_cnt_o,
   output logic           frame_start_o,
   output logic           active_o,
   output logic           hsync_o,
   output logic           vsync_o,
   output logic           de_o
);

   localparam logic [H_W-1:0] H_LAST  = H_W'(H_TOTAL - 1);
   localparam logic [H_W-1:0] H_ACT   = H_W'(H_ACTIVE);
   localparam logic [H_W-1:0] HS_BEG  = H_W'(H_ACTIVE + H_FP);
   localparam logic [H_W-1:0] HS_END  = H_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [V_W-1:0] V_LAST  = V_W'(V_TOTAL - 1);
   localparam logic [V_W-1:0] V_ACT   = V_W'(V_ACTIVE);
   localparam logic [V_W-1:0] VS_BEG  = V_W'(V_ACTIVE + V_FP);
   localparam logic [V_W-1:0] VS_END  = V_W'(V_ACTIVE + V_FP + V_SYNC);

   logic [H_W-1:0] h_cnt_q, h_cnt_d;
   logic [V_W-1:0] v_cnt_q, v_cnt_d;
   logic           hsync_q, hsync_d;
   logic           vsync_q, vsync_d;
   logic           de_q;

   assign active_o      = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
   assign frame_start_o = (h_cnt_q == '0) && (v_cnt_q == '0);

   // Next raster position and sync levels for the current position.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      h_cnt_d = h_cnt_q + H_W'(1);
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_LAST) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + V_W'(1);
      end
      hsync_d = ((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
      vsync_d = ((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END)) ? SYNC_POL : ~SYNC_POL;
   end

   // Raster counters and registered sync/enable, one cycle behind the counters.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         // NOTE: non-blocking assignments here so every flop samples pre-edge values.
         h_cnt_q <= '0;
         v_cnt_q <= '0;
         hsync_q <= ~SYNC_POL;
         vsync_q <= ~SYNC_POL;
         de_q    <= 1'b0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         de_q    <= active_o;
      end
   end

   assign h_cnt_o = h_cnt_q;
   assign v_cnt_o = v_cnt_q;
   assign hsync_o = hsync_q;
   assign vsync_o = vsync_q;
   assign de_o    = de_q;

endmodule

// File: rtl/latency_meas_gen.sv
// Display latency meter: drives a raster, flashes white from a frame start and
// timestamps the first rising edge seen on each photo-sensor channel.
module latency_meas_gen
   import latency_meas_pkg::*;
#(
   parameter int          H_ACTIVE     = DEF_H_ACTIVE,
   parameter int          H_FP         = DEF_H_FP,
   parameter int          H_SYNC       = DEF_H_SYNC,
   parameter int          H_BP         = DEF_H_BP,
   parameter int          V_ACTIVE     = DEF_V_ACTIVE,
   parameter int          V_FP         = DEF_V_FP,
   parameter int          V_SYNC       = DEF_V_SYNC,
   parameter int          V_BP         = DEF_V_BP,
   parameter bit          SYNC_POL     = 1'b1,
   parameter int          N_CH         = 2,
   parameter int          CNT_W        = 32,
   parameter int unsigned TIMEOUT_CLKS = 297_000_000
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic [2:0]            sw,
   input  logic                  start_in,
   input  logic                  clear_in,
   input  logic [N_CH-1:0]       sensor_in,
   output logic [23:0]           data_out,
   output logic                  hsync_out,
   output logic                  vsync_out,
   output logic                  de_out,
   output logic                  busy_out,
   output logic                  done_out,
   output logic                  timeout_out,
   output logic [N_CH-1:0]       hit_out,
   output logic [N_CH*CNT_W-1:0] latency_out,
   output logic [3:0]            led
);

   localparam int H_W = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
   localparam int V_W = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CLKS - 1);

   // Raw raster counters are available for other pattern generators; this
   // design only needs frame_start and the active flag.
   logic [H_W-1:0] h_cnt_unused;
   logic [V_W-1:0] v_cnt_unused;
   logic           frame_start;
   logic           active;

   state_e                      state_q, state_d;
   logic [CNT_W-1:0]            lat_cnt_q, lat_cnt_d;
   logic [N_CH-1:0]             hit_q, hit_d, new_hit;
   logic [N_CH-1:0][CNT_W-1:0]  latency_q, latency_d;
   logic                        timeout_q, timeout_d;
   logic [3:0]                  led_q, led_d;
   logic [23:0]                 data_q, data_d;
   logic [N_CH-1:0]             sync1_q, sync2_q, sync3_q;
   logic [N_CH-1:0]             rise;

   video_timing_gen #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP),
      .SYNC_POL (SYNC_POL)
   ) u_timing (
      .clk_i         (CLK),
      .rst_n_i       (RST_N),
      .h_cnt_o       (h_cnt_unused),
      .v_cnt_o       (v_cnt_unused),
      .frame_start_o (frame_start),
      .active_o      (active),
      .hsync_o       (hsync_out),
      .vsync_o       (vsync_out),
      .de_o          (de_out)
   );

   // Two-flop synchroniser per channel plus one history flop for edge detect.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync1_q <= '0;
         sync2_q <= '0;
         sync3_q <= '0;
      end else begin
         sync1_q <= sensor_in;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   assign rise = sync2_q & ~sync3_q;

   // Measurement FSM, latency counter, per-channel capture and sticky LEDs.
   always_comb begin
      state_d   = state_q;
      lat_cnt_d = lat_cnt_q;
      hit_d     = hit_q;
      latency_d = latency_q;
      timeout_d = timeout_q;
      new_hit   = '0;

      case (state_q)
         ST_IDLE: begin
            if (start_in) begin
               state_d   = ST_ARMED;
               lat_cnt_d = '0;
               hit_d     = '0;
               latency_d = '0;
               timeout_d = 1'b0;
            end
         end
         ST_ARMED: begin
            if (frame_start) begin
               state_d   = ST_FLASH;
               lat_cnt_d = '0;
            end
         end
         ST_FLASH: begin
            if (lat_cnt_q != '1) lat_cnt_d = lat_cnt_q + CNT_W'(1);
            new_hit = rise & ~hit_q;
            for (int i = 0; i < N_CH; i++) begin
               if (new_hit[i]) latency_d[i] = lat_cnt_q;
            end
            hit_d = hit_q | new_hit;
            // A final hit in the timeout cycle still counts as a clean finish.
            if (&hit_d) begin
               state_d = ST_DONE;
            end else if (lat_cnt_q == TIMEOUT_LAST) begin
               state_d   = ST_DONE;
               timeout_d = 1'b1;
            end
         end
         ST_DONE: ;
         default: state_d = ST_IDLE;
      endcase

      if (clear_in) begin
         state_d   = ST_IDLE;
         lat_cnt_d = '0;
         hit_d     = '0;
         latency_d = '0;
         timeout_d = 1'b0;
         led_d     = '0;
      end else begin
         led_d = led_q;
         if (state_d != ST_IDLE)                          led_d[LED_ARMED]   = 1'b1;
         if (state_d == ST_FLASH || state_d == ST_DONE)   led_d[LED_FLASH]   = 1'b1;
         if (|hit_d)                                      led_d[LED_HIT]     = 1'b1;
         if (timeout_d)                                   led_d[LED_TIMEOUT] = 1'b1;
      end
   end

   // Pixel mux uses the next state so white starts on the frame's first pixel.
   always_comb begin
      data_d = '0;
      if (active) data_d = (state_d == ST_FLASH) ? WHITE : idle_colour(sw);
   end

   // State and result registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         // NOTE: result registers are few and directly visible on outputs, so they all take reset.
         state_q   <= ST_IDLE;
         lat_cnt_q <= '0;
         hit_q     <= '0;
         latency_q <= '0;
         timeout_q <= 1'b0;
         led_q     <= '0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         lat_cnt_q <= lat_cnt_d;
         hit_q     <= hit_d;
         latency_q <= latency_d;
         timeout_q <= timeout_d;
         led_q     <= led_d;
         data_q    <= data_d;
      end
   end

   assign data_out    = data_q;
   assign busy_out    = (state_q == ST_ARMED) || (state_q == ST_FLASH);
   assign done_out    = (state_q == ST_DONE);
   assign timeout_out = timeout_q;
   assign hit_out     = hit_q;
   assign latency_out = latency_q;
   assign led         = led_q;

endmodule

// File: tb/tb_latency_meas_gen.sv
// Self-checking bench: a cycle-level behavioural model of the meter runs beside
// the DUT and is compared every cycle; directed literals pin key numbers.
module tb_latency_meas_gen;

   localparam int N_CH  = 2;
   localparam int CNT_W = 32;
   localparam int TO    = 1000;
   localparam int H_TOT = 24;
   localparam int V_TOT = 12;
   localparam int FRAME = H_TOT * V_TOT;

   localparam int M_IDLE  = 0;
   localparam int M_ARMED = 1;
   localparam int M_FLASH = 2;
   localparam int M_DONE  = 3;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b1;
   logic [2:0]            sw = 3'b101;
   logic                  start_in = 1'b0;
   logic                  clear_in = 1'b0;
   logic [N_CH-1:0]       sensor = '0;
   logic [23:0]           data_out;
   logic                  hsync_out, vsync_out, de_out;
   logic                  busy_out, done_out, timeout_out;
   logic [N_CH-1:0]       hit_out;
   logic [N_CH*CNT_W-1:0] latency_out;
   logic [3:0]            led;

   latency_meas_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(4),
      .V_ACTIVE(8),  .V_FP(1), .V_SYNC(1), .V_BP(2),
      .SYNC_POL(1'b1), .N_CH(N_CH), .CNT_W(CNT_W), .TIMEOUT_CLKS(TO)
   ) dut (
      .CLK(clk), .RST_N(rst_n), .sw(sw), .start_in(start_in), .clear_in(clear_in),
      .sensor_in(sensor), .data_out(data_out), .hsync_out(hsync_out),
      .vsync_out(vsync_out), .de_out(de_out), .busy_out(busy_out),
      .done_out(done_out), .timeout_out(timeout_out), .hit_out(hit_out),
      .latency_out(latency_out), .led(led)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          m_mode, m_k, m_pos, cyc;
   logic [1:0]  m_hit;
   logic [31:0] m_lat [2];
   logic        m_to;
   logic [3:0]  m_led;
   logic [1:0]  s_h1, s_h2, s_h3;
   logic        e_de, e_hs, e_vs;
   logic [23:0] e_data;

   function automatic logic [23:0] colour(input logic [2:0] s);
      return {s[2] ? 8'hFF : 8'h00, s[1] ? 8'hFF : 8'h00, s[0] ? 8'hFF : 8'h00};
   endfunction

   task automatic model_reset();
      m_mode = M_IDLE; m_k = 0; m_pos = 0; cyc = 0;
      m_hit = '0; m_lat[0] = '0; m_lat[1] = '0; m_to = 1'b0; m_led = '0;
      s_h1 = '0; s_h2 = '0; s_h3 = '0;
      e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_data = '0;
   endtask

   task automatic model_step();
      int h, v;
      logic [1:0] rise, newh;
      h = m_pos % H_TOT;
      v = m_pos / H_TOT;
      // A sample taken at edge e becomes a usable edge two cycles later.
      rise = s_h2 & ~s_h3;
      s_h3 = s_h2; s_h2 = s_h1; s_h1 = sensor;
      if (clear_in) begin
         m_mode = M_IDLE; m_hit = '0; m_lat[0] = '0; m_lat[1] = '0; m_to = 1'b0; m_led = '0;
      end else begin
         case (m_mode)
            M_IDLE: if (start_in) begin
               m_mode = M_ARMED; m_hit = '0; m_lat[0] = '0; m_lat[1] = '0; m_to = 1'b0;
            end
            M_ARMED: if (m_pos == 0) begin
               m_mode = M_FLASH; m_k = 0;
            end
            M_FLASH: begin
               newh = rise & ~m_hit;
               for (int i = 0; i < 2; i++) if (newh[i]) m_lat[i] = m_k;
               m_hit = m_hit | newh;
               if (m_hit == 2'b11) m_mode = M_DONE;
               else if (m_k == TO - 1) begin m_mode = M_DONE; m_to = 1'b1; end
               m_k++;
            end
            default: ;
         endcase
         if (m_mode != M_IDLE)  m_led[0] = 1'b1;
         if (m_mode >= M_FLASH) m_led[1] = 1'b1;
         if (|m_hit)            m_led[2] = 1'b1;
         if (m_to)              m_led[3] = 1'b1;
      end
      e_de   = (h < 16) && (v < 8);
      e_hs   = (h >= 18) && (h < 20);
      e_vs   = (v == 9);
      e_data = e_de ? ((m_mode == M_FLASH) ? 24'hFFFFFF : colour(sw)) : 24'h0;
      m_pos  = (m_pos + 1) % FRAME;
      cyc++;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else        model_step();
      end
   end

   // ---------------- per-cycle comparison ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            check("data_out", data_out, e_data);
            check("hsync", hsync_out, e_hs);
            check("vsync", vsync_out, e_vs);
            check("de", de_out, e_de);
            check("busy", busy_out, (m_mode == M_ARMED) || (m_mode == M_FLASH));
            check("done", done_out, m_mode == M_DONE);
            check("timeout", timeout_out, m_to);
            check("hit", hit_out, m_hit);
            check("latency", latency_out, {m_lat[1], m_lat[0]});
            check("led", led, m_led);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_mode(input int target, input int budget, input string name);
      int n = 0;
      while (m_mode != target && n < budget) begin @(negedge clk); n++; end
      check(name, m_mode, target);
   endtask

   task automatic wait_flash(input int c, input string name);
      int n = 0;
      while (!(m_mode == M_FLASH && m_k == c) && n < 2 * TO) begin @(negedge clk); n++; end
      check(name, m_k, c);
   endtask

   task automatic pulse_start();
      @(negedge clk); start_in = 1'b1;
      @(negedge clk); start_in = 1'b0;
   endtask

   task automatic pulse_clear();
      @(negedge clk); clear_in = 1'b1;
      @(negedge clk); clear_in = 1'b0;
   endtask

   task automatic start_and_flash(input string name);
      pulse_start();
      wait_mode(M_FLASH, FRAME + 8, name);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed scenarios ----------------
   initial begin
      int de_cnt, fc, dc, n;

      // Asynchronous reset before any clock edge.
      #1 rst_n = 1'b0;
      #1;
      check("rst_hsync", hsync_out, 1'b0);
      check("rst_vsync", vsync_out, 1'b0);
      check("rst_de", de_out, 1'b0);
      check("rst_data", data_out, 24'h0);
      check("rst_busy", busy_out, 1'b0);
      check("rst_led", led, 4'h0);
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      cmp_en = 1'b1;

      // Free run: outputs after edge k show raster position k-1.
      de_cnt = 0;
      for (int k = 1; k <= FRAME + 1; k++) begin
         @(negedge clk);
         if (k <= FRAME) de_cnt += int'(de_out);
         if (k == 1)   begin check("fr_pix0", data_out, 24'hFF00FF); check("fr_de0", de_out, 1'b1); end
         if (k == 16)  check("fr_de15", de_out, 1'b1);
         if (k == 17)  begin check("fr_de16", de_out, 1'b0); check("fr_blank16", data_out, 24'h0); end
         if (k == 18)  check("fr_hs17", hsync_out, 1'b0);
         if (k == 19)  check("fr_hs18", hsync_out, 1'b1);
         if (k == 20)  check("fr_hs19", hsync_out, 1'b1);
         if (k == 21)  check("fr_hs20", hsync_out, 1'b0);
         if (k == 43)  check("fr_hs_line1", hsync_out, 1'b1);
         if (k == 193) check("fr_de_line8", de_out, 1'b0);
         if (k == 216) check("fr_vs_line8", vsync_out, 1'b0);
         if (k == 217) check("fr_vs_line9", vsync_out, 1'b1);
         if (k == 241) check("fr_vs_line10", vsync_out, 1'b0);
         if (k == 289) check("fr_next_frame_de", de_out, 1'b1);
      end
      check("fr_de_count", de_cnt, 128);

      // Start mid-frame, flash from the next frame start, two staggered sensors.
      n = 0;
      while (m_pos != 100 && n < FRAME) begin @(negedge clk); n++; end
      pulse_start();
      check("armed_busy", busy_out, 1'b1);
      check("armed_led0", led[0], 1'b1);
      wait_mode(M_FLASH, FRAME + 8, "wait_flash1");
      check("flash_at_origin", m_pos, 1);
      check("flash_pix0", data_out, 24'hFFFFFF);
      check("flash_de0", de_out, 1'b1);
      wait_flash(20, "flash_c20");
      check("flash_blank", data_out, 24'h0);
      wait_flash(100, "flash_c100");
      sensor[0] = 1'b1;
      repeat (3) @(negedge clk);
      sensor[0] = 1'b0;
      wait_flash(350, "flash_c350");
      sensor[1] = 1'b1;
      repeat (3) @(negedge clk);
      sensor[1] = 1'b0;
      wait_mode(M_DONE, 20, "wait_done1");
      @(negedge clk);
      check("s1_lat0", latency_out[31:0], 32'd102);
      check("s1_lat1", latency_out[63:32], 32'd352);
      check("s1_hit", hit_out, 2'b11);
      check("s1_done", done_out, 1'b1);
      check("s1_timeout", timeout_out, 1'b0);
      check("s1_led", led, 4'b0111);

      // Timeout with a single channel hit.
      pulse_clear();
      check("clr_led", led, 4'h0);
      check("clr_lat", latency_out, 64'h0);
      start_and_flash("wait_flash2");
      fc = cyc;
      wait_flash(10, "flash_c10");
      sensor[0] = 1'b1;
      repeat (3) @(negedge clk);
      sensor[0] = 1'b0;
      wait_mode(M_DONE, TO + 20, "wait_done2");
      dc = cyc;
      check("to_duration", dc - fc, TO);
      check("to_timeout", timeout_out, 1'b1);
      check("to_hit", hit_out, 2'b01);
      check("to_lat0", latency_out[31:0], 32'd12);
      check("to_led3", led[3], 1'b1);

      // Held-high sensor must re-rise; repeated pulses on a hit channel ignored.
      pulse_clear();
      sensor[1] = 1'b1;
      start_and_flash("wait_flash3");
      wait_flash(20, "flash3_c20");
      sensor[0] = 1'b1;
      repeat (3) @(negedge clk);
      sensor[0] = 1'b0;
      wait_flash(50, "flash3_c50");
      sensor[0] = 1'b1;
      repeat (3) @(negedge clk);
      sensor[0] = 1'b0;
      wait_flash(60, "flash3_c60");
      sensor[1] = 1'b0;
      wait_flash(70, "flash3_c70");
      sensor[1] = 1'b1;
      wait_mode(M_DONE, 20, "wait_done3");
      sensor[1] = 1'b0;
      check("held_lat0", latency_out[31:0], 32'd22);
      check("held_lat1", latency_out[63:32], 32'd72);

      // Clear in FLASH, then clear beating a simultaneous start.
      pulse_clear();
      start_and_flash("wait_flash4");
      wait_flash(30, "flash4_c30");
      clear_in = 1'b1;
      @(negedge clk);
      clear_in = 1'b0;
      check("clr_flash_busy", busy_out, 1'b0);
      check("clr_flash_led", led, 4'h0);
      @(negedge clk);
      clear_in = 1'b1; start_in = 1'b1;
      @(negedge clk);
      clear_in = 1'b0; start_in = 1'b0;
      check("clr_wins_busy", busy_out, 1'b0);
      check("clr_wins_led", led, 4'h0);

      // Simultaneous edges capture the same count.
      start_and_flash("wait_flash5");
      wait_flash(40, "flash5_c40");
      sensor = 2'b11;
      repeat (3) @(negedge clk);
      sensor = 2'b00;
      wait_mode(M_DONE, 20, "wait_done5");
      check("sim_lat0", latency_out[31:0], 32'd42);
      check("sim_lat1", latency_out[63:32], 32'd42);

      // Asynchronous reset mid-line while results are held.
      n = 0;
      while (m_pos != 5 && n < FRAME) begin @(negedge clk); n++; end
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("arst_data", data_out, 24'h0);
      check("arst_hsync", hsync_out, 1'b0);
      check("arst_vsync", vsync_out, 1'b0);
      check("arst_de", de_out, 1'b0);
      check("arst_busy", busy_out, 1'b0);
      check("arst_done", done_out, 1'b0);
      check("arst_timeout", timeout_out, 1'b0);
      check("arst_hit", hit_out, 2'b00);
      check("arst_lat", latency_out, 64'h0);
      check("arst_led", led, 4'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
